// File: rtl/add8u_err_monitor_if.sv
// Handshake and result bus between a stimulus source and add8u_err_monitor.
interface add8u_err_monitor_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = CNT_W + W + 1
);
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W:0]       o_approx;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [W:0]       wce;
  logic [W-1:0]     wce_a;
  logic [W-1:0]     wce_b;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, n_samples, in_valid, a, b, o_approx,
    input  in_ready, busy, done, sample_cnt, err_sum, wce, wce_a, wce_b, err_cnt
  );

  modport slave (
    input  start, n_samples, in_valid, a, b, o_approx,
    output in_ready, busy, done, sample_cnt, err_sum, wce, wce_a, wce_b, err_cnt
  );
endinterface

// File: rtl/add8u_err_monitor.sv
// Error-metric collector for W-bit unsigned approximate adders: accumulates
// sum of absolute error, worst-case error (with its operands) and the count
// of erroneous samples over a run of n_samples triples.
module add8u_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = CNT_W + W + 1
) (
  input  logic                clk,
  input  logic                rst,
  add8u_err_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;

  logic             vld_p0;
  logic             start_ok;

  logic             vld_p1;
  logic [W-1:0]     a_p1;
  logic [W-1:0]     b_p1;
  logic [W:0]       err_p1;

  logic [CNT_W-1:0] sample_cnt_r;
  logic [SUM_W-1:0] err_sum_r;
  logic [W:0]       wce_r;
  logic [W-1:0]     wce_a_r;
  logic [W-1:0]     wce_b_r;
  logic [CNT_W-1:0] err_cnt_r;

  // |o - (x+y)| using a W+2-bit signed difference; magnitude always fits W+1 bits.
  function automatic logic [W:0] abs_err(input logic [W-1:0] op_a,
                                         input logic [W-1:0] op_b,
                                         input logic [W:0]   op_o);
    logic [W:0]          exact;
    logic signed [W+1:0] diff;
    exact = {1'b0, op_a} + {1'b0, op_b};
    diff  = $signed({1'b0, op_o}) - $signed({1'b0, exact});
    if (diff < 0) diff = -diff;
    return diff[W:0];
  endfunction

  // Stage 0: input handshake
  assign vld_p0   = bus.in_valid & in_ready_r;
  assign start_ok = bus.start & ((state == IDLE) | (state == DONE));

  // Run control FSM; in_ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      acc_cnt    <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            n_lat   <= bus.n_samples;
            acc_cnt <= '0;
            if (bus.n_samples == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state      <= RUN;
              busy_r     <= 1'b1;
              in_ready_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (vld_p0) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == n_lat - CNT_W'(1)) begin
              state      <= DRAIN;
              in_ready_r <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Stage 1 empty means the last sample has reached the accumulators.
          if (!vld_p1) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 valid bit: bubbles advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  // Stage 1 data: exact sum and absolute error, operands carried alongside.
  always_ff @(posedge clk) begin
    a_p1   <= bus.a;
    b_p1   <= bus.b;
    err_p1 <= abs_err(bus.a, bus.b, bus.o_approx);
  end

  // Stage 2: accumulators, cleared by an accepted start; strict > keeps the earliest tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_r <= '0;
      err_sum_r    <= '0;
      wce_r        <= '0;
      wce_a_r      <= '0;
      wce_b_r      <= '0;
      err_cnt_r    <= '0;
    end else if (start_ok) begin
      sample_cnt_r <= '0;
      err_sum_r    <= '0;
      wce_r        <= '0;
      wce_a_r      <= '0;
      wce_b_r      <= '0;
      err_cnt_r    <= '0;
    end else if (vld_p1) begin
      sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      err_sum_r    <= err_sum_r + SUM_W'(err_p1);
      err_cnt_r    <= err_cnt_r + CNT_W'(err_p1 != '0);
      if (err_p1 > wce_r) begin
        wce_r   <= err_p1;
        wce_a_r <= a_p1;
        wce_b_r <= b_p1;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.sample_cnt = sample_cnt_r;
  assign bus.err_sum    = err_sum_r;
  assign bus.wce        = wce_r;
  assign bus.wce_a      = wce_a_r;
  assign bus.wce_b      = wce_b_r;
  assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Self-checking bench for add8u_err_monitor: table of directed runs, chained
// start-on-DONE, randomized runs against a behavioural model, reset mid-run.
module tb_add8u_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  int qa[$];
  int qb[$];
  int qo[$];

  typedef struct {
    int n;
    int mode;      // 0: in_valid always 1, 1: fixed gap pattern, 2: random
    int restart;   // pulse start again while running
    int ta[4];
    int tb[4];
    int to[4];
    int e_sum;
    int e_wce;
    int e_wa;
    int e_wb;
    int e_cnt;
  } vec_t;

  vec_t tbl[5];
  bit   pat[7];

  add8u_err_monitor_if #(.W(W), .CNT_W(CNT_W)) bus();

  add8u_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},   bus.in_ready, 0);
    chk({tag, "_busy"},       bus.busy, 0);
    chk({tag, "_done"},       bus.done, 0);
    chk({tag, "_sample_cnt"}, bus.sample_cnt, 0);
    chk({tag, "_err_sum"},    bus.err_sum, 0);
    chk({tag, "_wce"},        bus.wce, 0);
    chk({tag, "_wce_a"},      bus.wce_a, 0);
    chk({tag, "_wce_b"},      bus.wce_b, 0);
    chk({tag, "_err_cnt"},    bus.err_cnt, 0);
  endtask

  // Reference: metrics straight from the definition over the queued triples.
  task automatic model(input int n, output int s, output int w, output int wa,
                       output int wb, output int ec);
    s = 0; w = 0; wa = 0; wb = 0; ec = 0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = qo[i] - (qa[i] + qb[i]);
      if (e < 0) e = -e;
      s += e;
      if (e != 0) ec++;
      if (e > w) begin
        w = e; wa = qa[i]; wb = qb[i];
      end
    end
  endtask

  task automatic check_results(input string tag, input int n, input int s, input int w,
                               input int wa, input int wb, input int ec);
    chk({tag, "_sample_cnt"}, bus.sample_cnt, n);
    chk({tag, "_err_sum"},    bus.err_sum, s);
    chk({tag, "_wce"},        bus.wce, w);
    chk({tag, "_wce_a"},      bus.wce_a, wa);
    chk({tag, "_wce_b"},      bus.wce_b, wb);
    chk({tag, "_err_cnt"},    bus.err_cnt, ec);
  endtask

  // One run: start, feed the queued triples under the chosen valid pattern,
  // check in_ready/busy every cycle and done timing. early=1 returns in the
  // DONE cycle so the next run's start coincides with done.
  task automatic run(input string tag, input int n, input int mode,
                     input int restart, input bit early);
    int  acc, last, dcnt, dcyc, t;
    bit  v, exp_ready;
    acc = 0; last = -1; dcnt = 0; dcyc = -1;
    bus.start     = 1'b1;
    bus.n_samples = CNT_W'(n);
    bus.in_valid  = 1'b0;
    step();
    t = cyc;
    bus.start = 1'b0;
    chk({tag, "_busy_after_start"}, bus.busy, (n != 0) ? 1 : 0);
    chk({tag, "_done_after_start"}, bus.done, (n == 0) ? 1 : 0);
    if (bus.done) begin
      dcnt = 1; dcyc = cyc;
    end
    for (int c = 0; c < 400; c++) begin
      if (dcnt > 0 && (early || cyc >= dcyc + 2)) break;
      exp_ready = (acc < n);
      chk({tag, "_in_ready"}, bus.in_ready, exp_ready);
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[c % 7];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.start = (restart != 0 && c == 2);
      if (restart != 0 && c == 2) bus.n_samples = CNT_W'(7);
      bus.in_valid = v;
      if (acc < n) begin
        bus.a = 8'(qa[acc]); bus.b = 8'(qb[acc]); bus.o_approx = 9'(qo[acc]);
      end else begin
        bus.a = 8'($urandom_range(0, 255)); bus.b = 8'($urandom_range(0, 255));
        bus.o_approx = 9'($urandom_range(0, 511));
      end
      step();
      if (v && exp_ready) begin
        acc++;
        if (acc == n) last = cyc;
      end
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) dcyc = cyc;
      end
      chk({tag, "_busy"}, bus.busy, (n != 0 && dcnt == 0) ? 1 : 0);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_done_seen"}, (dcnt > 0) ? 1 : 0, 1);
    if (!early) chk({tag, "_done_pulses"}, dcnt, 1);
    chk({tag, "_done_cycle"}, dcyc, (n == 0) ? t : last + 2);
  endtask

  task automatic load_vec(input vec_t v);
    qa.delete(); qb.delete(); qo.delete();
    for (int i = 0; i < v.n; i++) begin
      qa.push_back(v.ta[i]); qb.push_back(v.tb[i]); qo.push_back(v.to[i]);
    end
  endtask

  task automatic load_random(input int n);
    qa.delete(); qb.delete(); qo.delete();
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      qa.push_back(x);
      qb.push_back(y);
      case ($urandom_range(0, 2))
        0:       qo.push_back(x + y);
        1:       qo.push_back($urandom_range(0, 511));
        default: qo.push_back((x + y) ^ (1 << $urandom_range(0, 3)));
      endcase
    end
  endtask

  initial begin
    int s, w, wa, wb, ec, n;
    n_cmp = 0; n_bad = 0; cyc = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    tbl[0] = '{3, 0, 0, '{100, 255, 0, 0}, '{27, 255, 0, 0}, '{127, 510, 0, 0},   0,   0,   0,   0, 0};
    tbl[1] = '{3, 0, 0, '{5, 200, 0, 0},   '{3, 100, 0, 0},  '{12, 290, 0, 0},   14,  10, 200, 100, 2};
    tbl[2] = '{2, 0, 0, '{10, 1, 0, 0},    '{10, 1, 0, 0},   '{5, 17, 0, 0},     30,  15,  10,  10, 2};
    tbl[3] = '{4, 1, 1, '{1, 4, 255, 7},   '{2, 4, 1, 7},    '{3, 9, 0, 14},    257, 256, 255,   1, 2};
    tbl[4] = '{0, 2, 0, '{0, 0, 0, 0},     '{0, 0, 0, 0},    '{0, 0, 0, 0},       0,   0,   0,   0, 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.n_samples = '0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.o_approx = '0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      load_vec(tbl[i]);
      run(tag, tbl[i].n, tbl[i].mode, tbl[i].restart, 1'b0);
      check_results(tag, tbl[i].n, tbl[i].e_sum, tbl[i].e_wce, tbl[i].e_wa,
                    tbl[i].e_wb, tbl[i].e_cnt);
    end

    // start coincident with DONE: second run begins in the done cycle
    load_random(1);
    run("chain1", 1, 0, 0, 1'b1);
    load_random(2);
    run("chain2", 2, 0, 0, 1'b0);
    model(2, s, w, wa, wb, ec);
    check_results("chain2", 2, s, w, wa, wb, ec);

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("rnd%0d", r);
      n = $urandom_range(1, 12);
      load_random(n);
      run(tag, n, 2, 0, 1'b0);
      model(n, s, w, wa, wb, ec);
      check_results(tag, n, s, w, wa, wb, ec);
    end

    // Reset in the middle of a 5-sample run
    bus.n_samples = CNT_W'(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd9; bus.o_approx = 9'd20;
    step(); step();
    bus.in_valid = 1'b0;
    step();
    chk("pre_rst_cnt", bus.sample_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    step();
    rst = 1'b0;
    qa.delete(); qb.delete(); qo.delete();
    qa.push_back(5); qb.push_back(3); qo.push_back(12);
    run("post_rst", 1, 0, 0, 1'b0);
    check_results("post_rst", 1, 4, 4, 5, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add8u_err_monitor.md
# add8u_err_monitor

Sequential error-metric collector for 8-bit unsigned approximate adders. It consumes operand/result triples from an adder under test, recomputes the exact sum, and accumulates sum of absolute error, worst-case error with its operands, and erroneous-sample count over a run of N samples. It sits downstream of the combinational approximate-adder instances and supplies the MAE/WCE/EP figures used to characterise them.

## Interface
- `W`, 8: operand width; the adder result is W+1 bits.
- `CNT_W`, 16: width of the sample counters.
- `SUM_W`, CNT_W+W+1: width of the error accumulator, guaranteed non-overflowing.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that clears results and begins a run.
- `n_samples` in CNT_W: run length, sampled when `start` is accepted.
- `in_valid` in 1: a triple is presented.
- `in_ready` out 1: the monitor accepts the triple on this edge.
- `a`, `b` in W: operands.
- `o_approx` in W+1: the approximate adder's result.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse when the results are final.
- `sample_cnt` out CNT_W: number of accumulated samples.
- `err_sum` out SUM_W: Σ|o_approx − (a+b)|.
- `wce` out W+1: maximum absolute error.
- `wce_a`, `wce_b` out W: operands that produced `wce`.
- `err_cnt` out CNT_W: number of samples with nonzero error.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE/DONE + `start`:**
  - Clear all result outputs.
  - Latch `n_samples` and clear the accepted-sample counter.
  - Go to RUN, or to DONE if `n_samples` = 0.
- **Ignored `start`:** `start` in RUN or DRAIN has no effect.
- **RUN:**
  - `in_ready` = 1 while accepted < latched N.
  - Transfer occurs when `in_valid` && `in_ready`.
  - Go to DRAIN on the edge that accepts sample N.
- **DRAIN:**
  - `in_ready` = 0.
  - Go to DONE once the pipeline is empty.
- **DONE:**
  - `done` = 1 for exactly one cycle, then go to IDLE.
  - Results hold until the next accepted `start`.
- **Pipeline stage 1 (registered):**
  - exact = a + b, zero-extended to W+1.
  - err = |o_approx − exact|, computed in W+2-bit signed arithmetic with the magnitude taken into W+1 bits.
  - Register a and b alongside, plus a valid bit.
- **Pipeline stage 2 (registered):**
  - `err_sum` += err.
  - `sample_cnt` += 1.
  - `err_cnt` += (err ≠ 0).
  - If err > `wce` (strict), update `wce`, `wce_a` and `wce_b`. On a tie the earliest sample is kept.
- **Width rules:**
  - All arithmetic is unsigned apart from the signed stage-1 difference.
  - No saturation is needed: SUM_W ≥ CNT_W+W+1 covers the maximum error (2^(W+1)−1) times 2^CNT_W.

## Timing
- **Reset values:** state IDLE; `in_ready`, `busy` and `done` = 0; every result output and every internal counter = 0; pipeline valid bits = 0.
- **`start` at edge t:** `busy` = 1 from t+1, and `in_ready` may be 1 from t+1.
- **Latency:** a sample accepted at edge k updates stage 1 at k and the accumulators at k+1.
- **Last sample accepted at edge k:**
  - State is DRAIN after k.
  - Final accumulators are written at k+1.
  - State is DONE after k+2, so `done` is high in cycle k+2..k+3.
  - `busy` falls when DONE is entered.
- **n_samples = 0:** `start` at t gives `done` high in the cycle after t, and all results stay 0.
- **Backpressure:** `in_valid` gaps stall only the acceptance count. The pipeline advances every cycle and bubbles carry valid = 0.
- **`start` coincident with DONE:** accepted, and the new run begins. `done` still pulses that cycle.
- **Reset mid-run:** immediately returns everything to reset values. The partial run is discarded and the prior results are lost.

## Test plan
- **Exact-adder run:**
  - Stimulus: N=3, triples (100,27,127), (255,255,510), (0,0,0).
  - Required: `err_sum`=0, `wce`=0, `err_cnt`=0, `sample_cnt`=3; `done` pulses exactly once, 2 cycles after the last accept.
- **Mixed errors:**
  - Stimulus: N=3, triples (5,3,12), (200,100,290), (0,0,0).
  - Required: `err_sum`=14, `wce`=10, `wce_a`=200, `wce_b`=100, `err_cnt`=2.
- **Sign and tie handling:**
  - Stimulus: N=2, triples (10,10,5) then (1,1,17). Both have error 15.
  - Required: `wce`=15, `wce_a`=10, `wce_b`=10, `err_sum`=30.
- **Backpressure and gaps:**
  - Stimulus: N=4 with `in_valid` toggled 1,0,0,1,1,0,1; `start` pulsed again mid-RUN.
  - Required: exactly 4 transfers, `in_ready`=0 after the 4th, the second `start` ignored, `sample_cnt`=4.
- **Zero-length run:**
  - Stimulus: N=0.
  - Required: `done` the cycle after `start`, results 0, `in_ready` never 1.
- **Reset mid-run:**
  - Stimulus: `rst` after 2 of 5 samples.
  - Required: all outputs 0 and state IDLE. A following `start` with N=1 and triple (5,3,12) gives `err_sum`=4.
